// File: rtl/frame_tx_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_tx_streamer_if
// Brief    : Bundle between the frame streamer, the result-memory read port
//            and the UART transmitter handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_tx_streamer_if #(
    parameter int ADDR_W = 14
);
    // Blur stage / memory / transmitter -> streamer
    logic              data_process_finish;
    logic [7:0]        mem_data_in;
    logic              tx_busy;
    // Streamer -> memory / transmitter
    logic [ADDR_W-1:0] read_addr;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              sending;
    logic              send_finish;

    // Streamer side
    modport master (
        input  data_process_finish,
        input  mem_data_in,
        input  tx_busy,
        output read_addr,
        output tx_data,
        output tx_start,
        output sending,
        output send_finish
    );

    // Environment side (blur stage, result memory, transmitter)
    modport slave (
        output data_process_finish,
        output mem_data_in,
        output tx_busy,
        input  read_addr,
        input  tx_data,
        input  tx_start,
        input  sending,
        input  send_finish
    );
endinterface
`default_nettype wire

// File: rtl/frame_tx_streamer.sv
`default_nettype none
// ============================================================================
// Module   : frame_tx_streamer
// Brief    : Reads a processed IMG_W x IMG_H 8-bit frame out of result memory
//            in raster order and hands it byte by byte to a UART transmitter
//            using a start/busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module frame_tx_streamer #(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    frame_tx_streamer_if.master bus
);

    // Address of the last pixel of the frame.
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(IMG_W * IMG_H - 1);
    // WAIT is entered together with the address update; it lingers this many
    // extra clocks so CAPTURE samples exactly RD_LAT clocks after the address.
    localparam logic [1:0]        c_wait_extra = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    logic              r_prev;         // previous data_process_finish level
    logic [1:0]        r_lat_cnt;      // extra read-latency clocks spent in WAIT
    logic [7:0]        r_pix_buf;      // pixel captured from memory
    logic [ADDR_W-1:0] r_read_addr;
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_sending;
    logic              r_send_finish;

    // A frame starts only on a rising edge seen while no frame is running;
    // the edge register resets high so a level held through reset is inert.
    logic w_start;
    assign w_start = bus.data_process_finish & ~r_prev & ~r_sending;

    // Frame sequencer: address generation, read-latency wait, capture and
    // transmitter handshake, all with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_prev        <= 1'b1;
            r_lat_cnt     <= 2'd0;
            r_pix_buf     <= 8'd0;
            r_read_addr   <= '0;
            r_tx_data     <= 8'd0;
            r_tx_start    <= 1'b0;
            r_sending     <= 1'b0;
            r_send_finish <= 1'b0;
        end else begin
            // The edge register keeps tracking even mid-frame, so a level that
            // stays high cannot retrigger once the frame is done.
            r_prev     <= bus.data_process_finish;
            // tx_start is a single-clock pulse unless SEND re-asserts it.
            r_tx_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_read_addr   <= '0;
                        r_sending     <= 1'b1;
                        r_send_finish <= 1'b0;
                        r_lat_cnt     <= 2'd0;
                        r_state       <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_lat_cnt == c_wait_extra) begin
                        r_lat_cnt <= 2'd0;
                        r_state   <= ST_CAPTURE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end

                ST_CAPTURE: begin
                    r_pix_buf <= bus.mem_data_in;
                    r_state   <= ST_SEND;
                end

                ST_SEND: begin
                    // Byte is issued only into an idle transmitter; tx_data
                    // therefore changes only together with tx_start.
                    if (!bus.tx_busy) begin
                        r_tx_data  <= r_pix_buf;
                        r_tx_start <= 1'b1;
                        if (r_read_addr == c_last_addr) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_ADVANCE;
                        end
                    end
                end

                ST_ADVANCE: begin
                    // Prefetch the next pixel while the current byte shifts out.
                    r_read_addr <= r_read_addr + 1'b1;
                    r_state     <= ST_WAIT;
                end

                ST_DONE: begin
                    r_sending     <= 1'b0;
                    r_send_finish <= 1'b1;
                    r_state       <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.read_addr   = r_read_addr;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_start    = r_tx_start;
    assign bus.sending     = r_sending;
    assign bus.send_finish = r_send_finish;

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_tx_streamer
// Brief    : Self-checking bench for frame_tx_streamer. A full 100x100 frame
//            at RD_LAT=1 against a busy-counting transmitter model, plus a
//            4x2 frame at RD_LAT=3 driven from a cycle table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_tx_streamer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frame_tx_streamer_if #(.ADDR_W(14)) bus1 ();
    frame_tx_streamer_if #(.ADDR_W(4))  bus3 ();

    frame_tx_streamer #(.IMG_W(100), .IMG_H(100), .ADDR_W(14), .RD_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    frame_tx_streamer #(.IMG_W(4), .IMG_H(2), .ADDR_W(4), .RD_LAT(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- environment for the 100x100, RD_LAT=1 instance -------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: byte = addr[7:0], one clock of read latency.
    always @(posedge clk) bus1.mem_data_in <= bus1.read_addr[7:0];

    // Transmitter: busy for busy_len clocks after sampling tx_start.
    int   busy_len;
    logic force_busy;
    int   bcnt = 0;
    always @(posedge clk) begin
        if (bus1.tx_start) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign bus1.tx_busy = force_busy | (bcnt != 0);

    // Byte monitor: order, address, busy violation, spacing, finish rises.
    int   k = 0;
    int   frame_base;
    logic gap_on;
    int   data_err = 0, addr_err = 0, busy_err = 0, gap_err = 0, fin_rise = 0;
    int   last_cyc = 0;
    logic have_last = 1'b0;
    logic fin_prev = 1'b0;
    always @(negedge clk) begin
        if (!gap_on) have_last = 1'b0;
        if (bus1.tx_start === 1'b1) begin
            if (bus1.tx_data !== 8'(k - frame_base))    data_err++;
            if (bus1.read_addr !== 14'(k - frame_base)) addr_err++;
            if (bus1.tx_busy !== 1'b0)                  busy_err++;
            if (gap_on && have_last && (cyc - last_cyc) != 4) gap_err++;
            have_last = 1'b1;
            last_cyc  = cyc;
            k++;
        end
        if (bus1.send_finish === 1'b1 && !fin_prev) fin_rise++;
        fin_prev = bus1.send_finish;
    end

    task automatic wait_k(input int target, input int budget, input string name);
        int i = 0;
        while (k < target && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, 32'(k >= target), 32'd1);
    endtask

    // ---------------- environment for the 4x2, RD_LAT=3 instance ------------
    // Three-stage memory: data is valid only once the address has been stable
    // through all three stages, otherwise unknown.
    logic [3:0] a1, a2, a3;
    always @(posedge clk) begin
        a1 <= bus3.read_addr;
        a2 <= a1;
        a3 <= a2;
    end
    assign bus3.mem_data_in = (a1 == a2 && a2 == a3 && a3 == bus3.read_addr)
                              ? (8'h30 + {4'h0, a3}) : 8'hxx;

    typedef struct {
        logic       dpf;
        logic       busy;
        logic       start;
        logic       snd;
        logic [3:0] addr;
        logic [7:0] data;
        logic       fin;
    } vec_t;

    vec_t tbl[16];

    task automatic set_vec(input int i, input logic dpf, input logic busy, input logic start,
                           input logic snd, input logic [3:0] addr, input logic [7:0] data,
                           input logic fin);
        tbl[i].dpf   = dpf;
        tbl[i].busy  = busy;
        tbl[i].start = start;
        tbl[i].snd   = snd;
        tbl[i].addr  = addr;
        tbl[i].data  = data;
        tbl[i].fin   = fin;
    endtask

    initial begin
        int   first;
        int   n3, err3, sp3, c3, last3, kk, lim;
        logic [7:0] held;
        int   viol;

        //          i  dpf bsy start snd addr data  fin
        set_vec( 0, 1, 0, 0, 0, 4'd0, 8'h00, 0);  // level high since reset: no start
        set_vec( 1, 0, 0, 0, 0, 4'd0, 8'h00, 0);
        set_vec( 2, 1, 0, 0, 1, 4'd0, 8'h00, 0);  // rising edge -> WAIT
        set_vec( 3, 1, 0, 0, 1, 4'd0, 8'h00, 0);
        set_vec( 4, 1, 0, 0, 1, 4'd0, 8'h00, 0);
        set_vec( 5, 1, 0, 0, 1, 4'd0, 8'h00, 0);  // third WAIT clock
        set_vec( 6, 1, 0, 0, 1, 4'd0, 8'h00, 0);  // CAPTURE
        set_vec( 7, 1, 1, 0, 1, 4'd0, 8'h00, 0);  // SEND held by busy
        set_vec( 8, 1, 1, 0, 1, 4'd0, 8'h00, 0);
        set_vec( 9, 1, 0, 1, 1, 4'd0, 8'h30, 0);  // byte 0 issued
        set_vec(10, 1, 1, 0, 1, 4'd1, 8'h30, 0);  // ADVANCE
        set_vec(11, 0, 1, 0, 1, 4'd1, 8'h30, 0);
        set_vec(12, 1, 0, 0, 1, 4'd1, 8'h30, 0);  // edge mid-frame: ignored
        set_vec(13, 1, 0, 0, 1, 4'd1, 8'h30, 0);
        set_vec(14, 1, 0, 0, 1, 4'd1, 8'h30, 0);  // CAPTURE
        set_vec(15, 1, 0, 1, 1, 4'd1, 8'h31, 0);  // byte 1, 6 clocks after byte 0

        rst = 1'b1;
        bus1.data_process_finish = 1'b1;
        bus3.data_process_finish = 1'b1;
        bus3.tx_busy = 1'b0;
        force_busy = 1'b0;
        busy_len = 10;
        gap_on = 1'b0;
        frame_base = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs 100x100", 32'({bus1.read_addr, bus1.tx_data, bus1.tx_start,
                                            bus1.sending, bus1.send_finish}), 32'd0);
        check("reset outputs 4x2", 32'({bus3.read_addr, bus3.tx_data, bus3.tx_start,
                                        bus3.sending, bus3.send_finish}), 32'd0);
        rst = 1'b0;

        // ---- RD_LAT=3 cycle table ----
        for (int i = 0; i < 16; i++) begin
            bus3.data_process_finish = tbl[i].dpf;
            bus3.tx_busy = tbl[i].busy;
            @(posedge clk); #1;
            check($sformatf("lat3 vec %0d", i),
                  32'({bus3.tx_start, bus3.sending, bus3.read_addr, bus3.tx_data, bus3.send_finish}),
                  32'({tbl[i].start, tbl[i].snd, tbl[i].addr, tbl[i].data, tbl[i].fin}));
        end

        // ---- RD_LAT=3: rest of the frame with busy low ----
        bus3.tx_busy = 1'b0;
        n3 = 2; err3 = 0; sp3 = 0; c3 = 0; last3 = 0;
        while (bus3.send_finish !== 1'b1 && c3 < 200) begin
            @(posedge clk); #1;
            c3++;
            if (bus3.tx_start === 1'b1) begin
                if (bus3.tx_data !== 8'(48 + n3) || bus3.read_addr !== 4'(n3)) err3++;
                if (c3 - last3 != 6) sp3++;
                last3 = c3;
                n3++;
            end
        end
        check("lat3 byte count", 32'(n3), 32'd8);
        check("lat3 byte data", 32'(err3), 32'd0);
        check("lat3 spacing", 32'(sp3), 32'd0);
        check("lat3 done flags", 32'({bus3.sending, bus3.send_finish}), 32'b01);
        repeat (10) @(posedge clk);
        #1;
        check("lat3 finish held", 32'({bus3.sending, bus3.send_finish}), 32'b01);
        bus3.data_process_finish = 1'b0;
        @(posedge clk); #1;
        bus3.data_process_finish = 1'b1;
        @(posedge clk); #1;
        check("lat3 restart clears finish", 32'({bus3.sending, bus3.send_finish}), 32'b10);

        // ---- 100x100: level held through reset never started ----
        check("no start from held level", 32'({bus1.sending, bus1.tx_start}), 32'd0);
        check("no bytes before edge", 32'(k), 32'd0);

        // ---- first pulse latency ----
        bus1.data_process_finish = 1'b0;
        @(posedge clk); #1;
        bus1.data_process_finish = 1'b1;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus1.tx_start === 1'b1 && first == 0) first = i;
        end
        check("first tx_start latency", 32'(first), 32'd4);

        // ---- busy model active for the first 40 bytes, then tx_busy low ----
        wait_k(40, 2000, "reach byte 40");
        busy_len = 0;
        force_busy = 1'b1;
        held = bus1.tx_data;
        check("held byte before stall", 32'(held), 32'd39);
        viol = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus1.tx_start !== 1'b0 || bus1.tx_data !== held) viol++;
        end
        check("stall: no start, data held", 32'(viol), 32'd0);
        force_busy = 1'b0;
        @(posedge clk); #1;
        check("start on first idle clock", 32'({bus1.tx_start, bus1.tx_data}), 32'({1'b1, 8'd40}));

        gap_on = 1'b1;
        wait_k(500, 5000, "reach byte 500");
        bus1.data_process_finish = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus1.data_process_finish = 1'b1;

        lim = 0;
        while (bus1.send_finish !== 1'b1 && lim < 45000) begin
            @(posedge clk); #1;
            lim++;
        end
        check("frame finished", 32'(bus1.send_finish), 32'd1);
        check("frame byte count", 32'(k), 32'd10000);
        check("frame byte data", 32'(data_err), 32'd0);
        check("frame addresses", 32'(addr_err), 32'd0);
        check("no byte into busy tx", 32'(busy_err), 32'd0);
        check("4-clock spacing", 32'(gap_err), 32'd0);
        check("sending low at end", 32'(bus1.sending), 32'd0);

        repeat (100) @(posedge clk);
        #1;
        check("no retrigger byte count", 32'(k), 32'd10000);
        check("no retrigger flags", 32'({bus1.sending, bus1.send_finish}), 32'b01);
        check("single finish assertion", 32'(fin_rise), 32'd1);

        // ---- reset after 37 bytes of a second frame ----
        gap_on = 1'b0;
        frame_base = k;
        bus1.data_process_finish = 1'b0;
        @(posedge clk); #1;
        bus1.data_process_finish = 1'b1;
        wait_k(frame_base + 37, 1000, "reach 37 bytes");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("outputs cleared by rst", 32'({bus1.read_addr, bus1.tx_data, bus1.tx_start,
                                             bus1.sending, bus1.send_finish}), 32'd0);
        kk = k;
        repeat (200) @(posedge clk);
        #1;
        check("no byte after rst", 32'(k), 32'(kk));
        check("idle after rst", 32'({bus1.sending, bus1.send_finish}), 32'd0);

        frame_base = k;
        bus1.data_process_finish = 1'b0;
        @(posedge clk); #1;
        bus1.data_process_finish = 1'b1;
        wait_k(frame_base + 3, 100, "restart bytes");
        check("restart data/address from 0", 32'(data_err + addr_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
